// File: rtl/wb_mux_pkg.sv
// Shared types and helpers for the Wishbone 1:N decoder with watchdog.
// Holds the FSM encoding, cycle-type codes and select-width helper.
package wb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DECERR = 2'd2,
    TMO    = 2'd3
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Index width for n slaves; a single slave still needs a 1-bit index.
  function automatic int selw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_dec.sv
// Combinational priority address decoder: the lowest-index matching slave wins.
// Zero latency, no flow control.
module wb_addr_dec
  import wb_mux_pkg::*;
#(
  parameter int                       NUM_SLAVES = 8,
  parameter int                       AW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0,
  parameter int                       SELW       = selw(NUM_SLAVES)
) (
  input  logic [AW-1:0]   adr_i,
  output logic [SELW-1:0] idx_o,
  output logic            hit_o
);

  // Scan from the top so the lowest matching index is the last writer.
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((adr_i & MATCH_MASK[i*AW +: AW]) == MATCH_ADDR[i*AW +: AW]) begin
        idx_o = SELW'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_mux_tmo.sv
// Wishbone B4 classic 1:N decoder with a registered decode stage (1 cycle master->slave stb),
// cycle locking, decode-error response, per-transfer watchdog and error logging.
module wb_mux_tmo
  import wb_mux_pkg::*;
#(
  parameter int                       NUM_SLAVES = 8,
  parameter int                       AW         = 32,
  parameter int                       DW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0,
  parameter int                       TIMEOUT    = 1023,
  parameter int                       CNTW       = 16
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [AW-1:0]                wbm_adr_i,
  input  logic [DW-1:0]                wbm_dat_i,
  input  logic [DW/8-1:0]              wbm_sel_i,
  input  logic                         wbm_we_i,
  input  logic                         wbm_cyc_i,
  input  logic                         wbm_stb_i,
  input  logic [2:0]                   wbm_cti_i,
  input  logic [1:0]                   wbm_bte_i,
  output logic [DW-1:0]                wbm_dat_o,
  output logic                         wbm_ack_o,
  output logic                         wbm_err_o,
  output logic                         wbm_rty_o,
  output logic [NUM_SLAVES*AW-1:0]     wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0]     wbs_dat_o,
  output logic [NUM_SLAVES*DW/8-1:0]   wbs_sel_o,
  output logic [NUM_SLAVES-1:0]        wbs_we_o,
  output logic [NUM_SLAVES*3-1:0]      wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]      wbs_bte_o,
  output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]        wbs_stb_o,
  input  logic [NUM_SLAVES*DW-1:0]     wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]        wbs_err_i,
  input  logic [NUM_SLAVES-1:0]        wbs_rty_i,
  output logic                         tmo_o,
  output logic [CNTW-1:0]              err_cnt_o,
  output logic [AW-1:0]                err_adr_o
);

  localparam int            SELW  = selw(NUM_SLAVES);
  localparam int            TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_idx_q, sel_idx_d;
  logic            sel_vld_q, sel_vld_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CNTW-1:0] err_cnt_q, err_cnt_d;
  logic [AW-1:0]   err_adr_q, err_adr_d;

  logic [SELW-1:0] dec_idx;
  logic            dec_hit;
  logic            act, live, resp, err_log;
  logic            s_ack, s_err, s_rty;
  logic [DW-1:0]   s_dat;

  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

  wb_addr_dec #(
    .NUM_SLAVES (NUM_SLAVES),
    .AW         (AW),
    .MATCH_ADDR (MATCH_ADDR),
    .MATCH_MASK (MATCH_MASK),
    .SELW       (SELW)
  ) u_dec (
    .adr_i (wbm_adr_i),
    .idx_o (dec_idx),
    .hit_o (dec_hit)
  );

  assign act     = (state_q == ACTIVE) && sel_vld_q;
  assign live    = act && wbm_cyc_i;
  assign s_ack   = wbs_ack_i[sel_idx_q];
  assign s_err   = wbs_err_i[sel_idx_q];
  assign s_rty   = wbs_rty_i[sel_idx_q];
  assign s_dat   = wbs_dat_i[sel_idx_q*DW +: DW];
  assign resp    = s_ack || s_err || s_rty;
  assign err_log = (state_q == DECERR) || (state_q == TMO);

  // Slave cyc follows the master combinationally so a master abort is seen at once.
  always_comb begin
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    if (act) begin
      wbs_cyc_o[sel_idx_q] = wbm_cyc_i;
      wbs_stb_o[sel_idx_q] = wbm_stb_i;
    end
  end

  assign wbm_ack_o = live && s_ack;
  assign wbm_rty_o = live && s_rty;
  assign wbm_err_o = (live && s_err) || err_log;
  assign wbm_dat_o = live ? s_dat : '0;
  assign tmo_o     = (state_q == TMO);
  assign err_cnt_o = err_cnt_q;
  assign err_adr_o = err_adr_q;

  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    sel_vld_d = sel_vld_q;
    timer_d   = timer_q;
    err_cnt_d = err_cnt_q;
    err_adr_d = err_adr_q;
    case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          sel_idx_d = dec_idx;
          sel_vld_d = dec_hit;
          timer_d   = '0;
          state_d   = dec_hit ? ACTIVE : DECERR;
        end
      end
      ACTIVE: begin
        if (!wbm_cyc_i) begin
          state_d   = IDLE;
          sel_vld_d = 1'b0;
        end else if (resp) begin
          timer_d = '0;
        end else if (wbm_stb_i) begin
          if (timer_q == TLAST) begin
            state_d   = TMO;
            sel_vld_d = 1'b0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        sel_vld_d = 1'b0;
      end
    endcase
    if (err_log) begin
      err_adr_d = wbm_adr_i;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      sel_idx_q <= '0;
      sel_vld_q <= 1'b0;
      timer_q   <= '0;
      err_cnt_q <= '0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_idx_q <= sel_idx_d;
      sel_vld_q <= sel_vld_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
      err_adr_q <= err_adr_d;
    end
  end

endmodule

// File: tb/tb_wb_mux_tmo.sv
// Directed bench for wb_mux_tmo: 8-slave map, 16-cycle watchdog, 4-bit error counter.
module tb_wb_mux_tmo;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [N*AW-1:0] MADDR = {32'h7000, 32'h6000, 32'h5000, 32'h4000,
                                       32'h3000, 32'h1040, 32'h2000, 32'h0000};
  localparam logic [N*AW-1:0] MMASK = {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000,
                                       32'hFFFFF000, 32'hFFFFFFC0, 32'hFFFFF000, 32'hFFFFF000};

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   wdat;
  logic [3:0]      sel;
  logic            we, cyc, stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [DW-1:0]   wbm_dat_o;
  logic            wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [N*AW-1:0] wbs_adr_o;
  logic [N*DW-1:0] wbs_dat_o;
  logic [N*4-1:0]  wbs_sel_o;
  logic [N-1:0]    wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [N*3-1:0]  wbs_cti_o;
  logic [N*2-1:0]  wbs_bte_o;
  logic [N*DW-1:0] wbs_dat_i;
  logic [N-1:0]    wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic            tmo_o;
  logic [3:0]      err_cnt_o;
  logic [AW-1:0]   err_adr_o;

  logic [N-1:0]    s_ack;
  logic [7:0]      s_cnt [N];
  int              n_chk = 0;
  int              n_pass = 0;

  always #5 clk = ~clk;

  wb_mux_tmo #(
    .NUM_SLAVES (N), .AW (AW), .DW (DW),
    .MATCH_ADDR (MADDR), .MATCH_MASK (MMASK),
    .TIMEOUT (16), .CNTW (4)
  ) dut (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbm_adr_i (adr), .wbm_dat_i (wdat), .wbm_sel_i (sel), .wbm_we_i (we),
    .wbm_cyc_i (cyc), .wbm_stb_i (stb), .wbm_cti_i (cti), .wbm_bte_i (bte),
    .wbm_dat_o (wbm_dat_o), .wbm_ack_o (wbm_ack_o), .wbm_err_o (wbm_err_o), .wbm_rty_o (wbm_rty_o),
    .wbs_adr_o (wbs_adr_o), .wbs_dat_o (wbs_dat_o), .wbs_sel_o (wbs_sel_o), .wbs_we_o (wbs_we_o),
    .wbs_cti_o (wbs_cti_o), .wbs_bte_o (wbs_bte_o), .wbs_cyc_o (wbs_cyc_o), .wbs_stb_o (wbs_stb_o),
    .wbs_dat_i (wbs_dat_i), .wbs_ack_i (wbs_ack_i), .wbs_err_i (wbs_err_i), .wbs_rty_i (wbs_rty_i),
    .tmo_o (tmo_o), .err_cnt_o (err_cnt_o), .err_adr_o (err_adr_o)
  );

  // Slave i returns {D0, i, 0, adr[15:0]}; slave 2 acks after 2 cycles, slave 3 never acks.
  for (genvar g = 0; g < N; g++) begin : g_sdat
    assign wbs_dat_i[g*DW +: DW] = {8'hD0, 4'(g), 4'h0, wbs_adr_o[g*AW +: 16]};
  end
  assign wbs_ack_i = s_ack;
  assign wbs_err_i = '0;
  assign wbs_rty_i = '0;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        s_ack[i] <= 1'b0;
        s_cnt[i] <= 8'd0;
      end else if (wbs_cyc_o[i] && wbs_stb_o[i] && !s_ack[i] && i != 3) begin
        if (s_cnt[i] == ((i == 2) ? 8'd1 : 8'd0)) begin
          s_ack[i] <= 1'b1;
          s_cnt[i] <= 8'd0;
        end else begin
          s_cnt[i] <= s_cnt[i] + 8'd1;
        end
      end else begin
        s_ack[i] <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_bus();
    cyc = 1'b0;
    stb = 1'b0;
    cti = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acks;
    int w;
    rst = 1'b1; adr = '0; wdat = 32'h1234_5678; sel = 4'hF; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_cyc", wbs_cyc_o, 0);
    check("rst_err", wbm_err_o, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ack", wbm_ack_o, 0);
    check("idle_rty", wbm_rty_o, 0);
    check("idle_dat", wbm_dat_o, 0);
    check("idle_tmo", tmo_o, 0);
    check("idle_cnt", err_cnt_o, 0);
    check("idle_eadr", err_adr_o, 0);

    // Read from slave 2 with a 2-cycle ack.
    adr = 32'h1044; cyc = 1'b1; stb = 1'b1;
    #1 check("t1_stb_pre", wbs_stb_o, 0);
    @(negedge clk);
    check("t1_stb", wbs_stb_o, 8'h04);
    check("t1_ack0", wbm_ack_o, 0);
    @(negedge clk);
    check("t1_ack1", wbm_ack_o, 0);
    @(negedge clk);
    check("t1_ack2", wbm_ack_o, 1);
    check("t1_dat", wbm_dat_o, 32'hD020_1044);
    check("t1_err", wbm_err_o, 0);
    idle_bus();
    @(negedge clk);
    check("t1_cyc_off", wbs_cyc_o, 0);

    // Unmapped access.
    adr = 32'h8000; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    check("t2_err", wbm_err_o, 1);
    check("t2_stb", wbs_stb_o, 0);
    idle_bus();
    @(negedge clk);
    check("t2_err_off", wbm_err_o, 0);
    check("t2_cnt", err_cnt_o, 1);
    check("t2_eadr", err_adr_o, 32'h8000);

    // Slave 3 never acks: watchdog fires 16 cycles after slave stb.
    adr = 32'h3000; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    check("t3_stb", wbs_stb_o, 8'h08);
    repeat (15) @(negedge clk);
    check("t3_tmo_early", tmo_o, 0);
    check("t3_err_early", wbm_err_o, 0);
    check("t3_stb_late", wbs_stb_o, 8'h08);
    @(negedge clk);
    check("t3_tmo", tmo_o, 1);
    check("t3_err", wbm_err_o, 1);
    check("t3_cyc_off", wbs_cyc_o, 0);
    idle_bus();
    @(negedge clk);
    check("t3_tmo_off", tmo_o, 0);
    check("t3_cnt", err_cnt_o, 2);
    check("t3_eadr", err_adr_o, 32'h3000);

    // INCR burst to slave 0; last beat crosses into unmapped 0x1000 but stays locked.
    acks = 0;
    cyc = 1'b1; stb = 1'b1;
    for (int b = 0; b < 4; b++) begin
      adr = 32'h0FF4 + 32'(b * 4);
      cti = (b == 3) ? 3'b111 : 3'b010;
      w = 0;
      @(negedge clk);
      while (!wbm_ack_o && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (wbm_ack_o) acks++;
      check("t4_ack", wbm_ack_o, 1);
      check("t4_stb", wbs_stb_o, 8'h01);
      check("t4_dat", wbm_dat_o, {16'hD000, adr[15:0]});
      if (b == 3) check("t4_cti_eob", wbs_cti_o[2:0], 3'b111);
    end
    idle_bus();
    check("t4_acks", acks, 4);
    @(negedge clk);
    check("t4_err", wbm_err_o, 0);
    check("t4_cnt", err_cnt_o, 2);

    // Synchronous reset in the middle of an active transfer.
    adr = 32'h3000; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    check("t5_stb", wbs_stb_o, 8'h08);
    rst = 1'b1;
    @(negedge clk);
    check("t5_cyc", wbs_cyc_o, 0);
    check("t5_cnt", err_cnt_o, 0);
    check("t5_eadr", err_adr_o, 0);
    check("t5_err", wbm_err_o, 0);
    rst = 1'b0;
    idle_bus();
    @(negedge clk);

    // Counter saturation at 4'hF.
    for (int k = 0; k < 17; k++) begin
      adr = 32'h8000 + 32'(k * 4); cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      check("t6_err", wbm_err_o, 1);
      idle_bus();
      @(negedge clk);
      check("t6_cnt", err_cnt_o, (k < 15) ? k + 1 : 15);
    end
    check("t6_eadr", err_adr_o, 32'h8040);

    // Held strobe on an unmapped address: one err every two cycles.
    adr = 32'h9000; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    check("t7_err0", wbm_err_o, 1);
    @(negedge clk);
    check("t7_err1", wbm_err_o, 0);
    @(negedge clk);
    check("t7_err2", wbm_err_o, 1);
    idle_bus();
    @(negedge clk);
    check("t7_err3", wbm_err_o, 0);
    check("t7_eadr", err_adr_o, 32'h9000);
    check("t7_cnt", err_cnt_o, 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
